// File: rtl/traffic_pkg.sv
// Shared lamp codes and phase encodings for the traffic phase scheduler.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10
    } phase_e;

endpackage

// File: rtl/tl_rr_pick.sv
// Combinational round-robin picker: first set bit of pend at or after start (mod N).
module tl_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pend,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] win
);

    int best;

    // Smallest rotated distance from start wins.
    always_comb begin
        best  = N;
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < N; j++) begin
            if (pend[j] && ((j - int'(start) + N) % N) < best) begin
                best  = (j - int'(start) + N) % N;
                win   = IW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Round-robin green-time sequencer for N_APP approaches, timed in external ticks.
// Optional emergency preemption ports and behaviour are enabled by TRAFFIC_PREEMPT_EN.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int N_APP     = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int CNT_W     = 5,
    localparam int ID_W     = (N_APP > 2) ? $clog2(N_APP) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [N_APP-1:0]     req,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                 preempt,
    input  logic [ID_W-1:0]      preempt_id,
`endif
    output logic [3*N_APP-1:0]   lamps,
    output logic [ID_W-1:0]      active_id,
    output logic [1:0]           phase,
    output logic [N_APP-1:0]     pending
);

    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] G_MAX    = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W:0]   G_MIN    = (CNT_W+1)'(GREEN_MIN);

    phase_e                   phase_q, phase_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [CNT_W:0]           cnt_inc;
    logic [ID_W-1:0]          active_q, active_d, start_idx, rr_win, win;
    logic [N_APP-1:0]         pending_q, pending_d, act_oh;
    logic [N_APP-1:0][2:0]    lamps_q, lamps_d;
    logic                     rr_found, others, pre_cut, pre_hold;

    assign cnt_inc   = {1'b0, count_q} + (CNT_W+1)'(1);
    assign act_oh    = N_APP'(1) << active_q;
    assign others    = |(pending_q & ~act_oh);
    assign start_idx = (active_q == ID_W'(N_APP - 1)) ? '0 : active_q + 1'b1;

    tl_rr_pick #(.N(N_APP), .IW(ID_W)) u_pick (
        .pend  (pending_q),
        .start (start_idx),
        .found (rr_found),
        .win   (rr_win)
    );

`ifdef TRAFFIC_PREEMPT_EN
    assign pre_cut  = preempt && (active_q != preempt_id);
    assign pre_hold = preempt && (active_q == preempt_id);
    assign win      = preempt ? preempt_id : (rr_found ? rr_win : '0);
`else
    assign pre_cut  = 1'b0;
    assign pre_hold = 1'b0;
    assign win      = rr_found ? rr_win : '0;
`endif

    always_comb begin
        phase_d   = phase_q;
        count_d   = count_q;
        active_d  = active_q;
        // The approach currently green does not re-request itself.
        pending_d = pending_q | (req & ~((phase_q == PH_GREEN) ? act_oh : '0));
        case (phase_q)
            PH_ALL_RED: if (tick) begin
                if (count_q == AR_LAST) begin
                    phase_d   = PH_GREEN;
                    count_d   = '0;
                    active_d  = win;
                    pending_d = pending_d & ~(N_APP'(1) << win);
                end else begin
                    count_d = cnt_inc[CNT_W-1:0];
                end
            end
            PH_GREEN: begin
                if (pre_cut) begin
                    phase_d = PH_YELLOW;
                    count_d = '0;
                end else if (tick) begin
                    // GREEN_MAX >= GREEN_MIN, so the min test also covers the max cut-off.
                    if (!pre_hold && others && cnt_inc >= G_MIN) begin
                        phase_d = PH_YELLOW;
                        count_d = '0;
                    end else if (count_q < G_MAX) begin
                        count_d = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            PH_YELLOW: if (tick) begin
                if (count_q == YEL_LAST) begin
                    phase_d = PH_ALL_RED;
                    count_d = '0;
                end else begin
                    count_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                count_d = '0;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_APP; i++) begin
            lamps_d[i] = LAMP_RED;
            if (active_d == ID_W'(i) && phase_d == PH_GREEN)  lamps_d[i] = LAMP_GREEN;
            if (active_d == ID_W'(i) && phase_d == PH_YELLOW) lamps_d[i] = LAMP_YELLOW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_ALL_RED;
            count_q   <= '0;
            active_q  <= '0;
            pending_q <= '0;
            lamps_q   <= {N_APP{LAMP_RED}};
        end else begin
            phase_q   <= phase_d;
            count_q   <= count_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            lamps_q   <= lamps_d;
        end
    end

    assign lamps     = lamps_q;
    assign active_id = active_q;
    assign phase     = phase_q;
    assign pending   = pending_q;

endmodule
